// File: rtl/qr_iter_engine_pkg.sv
// qr_iter_engine_pkg: shared types, rotation constants and rotate helper for the ARX engine
package qr_iter_engine_pkg;
   typedef enum logic {QR_CHACHA, QR_SALSA} qr_mode_e;
   typedef enum logic [1:0] {IDLE, RUN, DONE} qr_state_e;
   localparam int CHACHA_ROT [4] = '{16, 12, 8, 7};
   localparam int SALSA_ROT [4] = '{7, 9, 13, 18};
   // Width-generic rotate on a 64-bit carrier; amount wraps modulo width
   function automatic logic [63:0] rotl(input logic [63:0] word, input int unsigned amt,
                                        input int unsigned width);
      int unsigned s;
      logic [63:0] m;
      s = amt % width;
      m = (width >= 64) ? '1 : (64'd1 << width) - 64'd1;
      word = word & m;
      return (s == 0) ? word : ((word << s) | (word >> (width - s))) & m;
   endfunction
endpackage

// File: rtl/qr_iter_engine_if.sv
// qr_iter_engine_if: job request / result handshake bundle for the quarter-round engine
interface qr_iter_engine_if
   import qr_iter_engine_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER_W = 5
);
   logic              in_valid;
   logic              in_ready;
   qr_mode_e          mode;
   logic [ITER_W-1:0] iter_cnt;
   logic [WIDTH-1:0]  a, b, c, d;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  a_prim, b_prim, c_prim, d_prim;
   logic              sat;
   logic              busy;
   modport master (
      output in_valid, mode, iter_cnt, a, b, c, d, out_ready,
      input  in_ready, out_valid, a_prim, b_prim, c_prim, d_prim, sat, busy
   );
   modport slave (
      input  in_valid, mode, iter_cnt, a, b, c, d, out_ready,
      output in_ready, out_valid, a_prim, b_prim, c_prim, d_prim, sat, busy
   );
endinterface

// File: rtl/qr_iter_engine_step.sv
// qr_step: one combinational ChaCha or Salsa20 quarter-round over words {d,c,b,a}
module qr_step
   import qr_iter_engine_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  qr_mode_e              mode_i,
   input  logic [3:0][WIDTH-1:0] w_i,
   output logic [3:0][WIDTH-1:0] w_o
);
   function automatic logic [WIDTH-1:0] r(input logic [WIDTH-1:0] x, input int unsigned k);
      return WIDTH'(rotl(64'(x), k, WIDTH));
   endfunction
   logic [WIDTH-1:0] ca1, cd1, cc1, cb1, ca2, cd2, cc2, cb2;
   logic [WIDTH-1:0] sb, sc, sd, sa;
   assign ca1 = w_i[0] + w_i[1];
   assign cd1 = r(w_i[3] ^ ca1, CHACHA_ROT[0]);
   assign cc1 = w_i[2] + cd1;
   assign cb1 = r(w_i[1] ^ cc1, CHACHA_ROT[1]);
   assign ca2 = ca1 + cb1;
   assign cd2 = r(cd1 ^ ca2, CHACHA_ROT[2]);
   assign cc2 = cc1 + cd2;
   assign cb2 = r(cb1 ^ cc2, CHACHA_ROT[3]);
   assign sb = w_i[1] ^ r(w_i[0] + w_i[3], SALSA_ROT[0]);
   assign sc = w_i[2] ^ r(sb + w_i[0], SALSA_ROT[1]);
   assign sd = w_i[3] ^ r(sc + sb, SALSA_ROT[2]);
   assign sa = w_i[0] ^ r(sd + sc, SALSA_ROT[3]);
   assign w_o = (mode_i == QR_SALSA) ? {sd, sc, sb, sa} : {cd2, cc2, cb2, ca2};
endmodule

// File: rtl/qr_iter_engine.sv
// qr_iter_engine: iterative ARX quarter-round engine, one round per cycle with valid/ready jobs
module qr_iter_engine
   import qr_iter_engine_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int MAX_ITER = 20,
   parameter int ITER_W = 5,
   parameter int FEED_FWD = 0
) (
   input logic             clk,
   input logic             reset,
   qr_iter_engine_if.slave bus
);
   qr_state_e             state_q, state_d;
   logic [ITER_W-1:0]     cnt_q, cnt_d;
   qr_mode_e              mode_q, mode_d;
   logic [3:0][WIDTH-1:0] w_q, w_d, in_q, in_d, step_w;
   logic                  sat_q, sat_d, over;
   assign over = bus.iter_cnt > ITER_W'(MAX_ITER);
   qr_step #(.WIDTH(WIDTH)) u_step (.mode_i(mode_q), .w_i(w_q), .w_o(step_w));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      w_d     = w_q;
      in_d    = in_q;
      sat_d   = sat_q;
      if (state_q == IDLE && bus.in_valid) begin
         state_d = RUN;
         cnt_d   = over ? ITER_W'(MAX_ITER) : bus.iter_cnt;
         mode_d  = bus.mode;
         w_d     = {bus.d, bus.c, bus.b, bus.a};
         in_d    = {bus.d, bus.c, bus.b, bus.a};
         sat_d   = over;
      end else if (state_q == RUN && cnt_q != '0) begin
         w_d   = step_w;
         cnt_d = cnt_q - ITER_W'(1);
      end else if (state_q == RUN) begin
         state_d = DONE;
         // Feed-forward is folded in exactly once, on the way into DONE
         if (FEED_FWD != 0)
            for (int i = 0; i < 4; i++) w_d[i] = w_q[i] + in_q[i];
      end else if (state_q == DONE && bus.out_ready) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= QR_CHACHA;
         w_q     <= '0;
         in_q    <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         w_q     <= w_d;
         in_q    <= in_d;
         sat_q   <= sat_d;
      end
   end
   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.busy      = state_q != IDLE;
   assign bus.sat       = sat_q;
   assign bus.a_prim    = w_q[0];
   assign bus.b_prim    = w_q[1];
   assign bus.c_prim    = w_q[2];
   assign bus.d_prim    = w_q[3];
endmodule

// File: tb/tb_qr_iter_engine.sv
// tb_qr_iter_engine: randomized jobs against a behavioural quarter-round model plus known vectors
module tb_qr_iter_engine;
   import qr_iter_engine_pkg::*;
   localparam int WIDTH = 32;
   localparam int MAX_ITER = 20;
   localparam int ITER_W = 5;
   localparam int FEED_FWD = 0;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   qr_iter_engine_if #(.WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();
   qr_iter_engine #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .FEED_FWD(FEED_FWD))
      dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction
   function automatic logic [127:0] model(input bit salsa, input int n, input logic [127:0] w);
      logic [31:0] a, b, c, d;
      {d, c, b, a} = w;
      for (int i = 0; i < n; i++) begin
         if (!salsa) begin
            a += b; d ^= a; d = rl(d, 16); c += d; b ^= c; b = rl(b, 12);
            a += b; d ^= a; d = rl(d, 8);  c += d; b ^= c; b = rl(b, 7);
         end else begin
            b ^= rl(32'(a + d), 7);
            c ^= rl(32'(b + a), 9);
            d ^= rl(32'(c + b), 13);
            a ^= rl(32'(d + c), 18);
         end
      end
      if (FEED_FWD != 0) begin
         a += w[31:0]; b += w[63:32]; c += w[95:64]; d += w[127:96];
      end
      return {d, c, b, a};
   endfunction
   function automatic logic [127:0] outw();
      return {bus.d_prim, bus.c_prim, bus.b_prim, bus.a_prim};
   endfunction
   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic start_job(input bit salsa, input int it, input logic [127:0] w);
      int t = 0;
      while (!bus.in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      check("in_ready_wait", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.mode = qr_mode_e'(salsa);
      bus.iter_cnt = ITER_W'(it);
      {bus.d, bus.c, bus.b, bus.a} = w;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.mode = qr_mode_e'($urandom_range(0, 1));
      bus.iter_cnt = ITER_W'($urandom);
      {bus.d, bus.c, bus.b, bus.a} = rnd();
   endtask
   task automatic do_job(input bit salsa, input int it, input logic [127:0] w, input int hold,
                         output logic [127:0] res);
      int lat = 0;
      int ni = (it > MAX_ITER) ? MAX_ITER : it;
      logic [127:0] exp = model(salsa, ni, w);
      bus.out_ready = (hold == 0);
      start_job(salsa, it, w);
      check("run_flags", {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      check("latency", lat, ni + 1);
      res = outw();
      check("result", res, exp);
      check("sat", bus.sat, it > MAX_ITER);
      check("done_flags", {bus.busy, bus.in_ready}, 2'b10);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("hold", {bus.out_valid, bus.in_ready, bus.sat, outw()},
               {1'b1, 1'b0, it > MAX_ITER, exp});
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("handoff", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
   endtask
   initial begin
      logic [127:0] w, res;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.mode = QR_CHACHA;
      bus.iter_cnt = '0;
      {bus.d, bus.c, bus.b, bus.a} = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", {bus.in_ready, bus.out_valid, bus.busy, bus.sat}, 4'b1000);
      check("rst_words", outw(), '0);
      reset = 1'b0;
      do_job(0, 1, 128'h01234567_9b8d6f43_01020304_11111111, 0, res);
      check("vec_chacha", res, 128'h5881c4bb_4581472e_cb1cf8ce_ea2a92f4);
      do_job(1, 1, 128'h1, 0, res);
      check("vec_salsa", res, 128'h20500000_00010200_00000080_08008145);
      w = rnd();
      do_job(1, 0, w, 0, res);
      check("iter0_pass", res, w);
      do_job(0, 31, rnd(), 0, res);
      do_job(1, 21, rnd(), 0, res);
      do_job(0, 20, rnd(), 0, res);
      do_job(0, 7, rnd(), 10, res);
      w = rnd();
      start_job(0, 10, w);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("mid_busy", bus.busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_flags", {bus.out_valid, bus.in_ready, bus.busy, bus.sat}, 4'b0100);
      check("abort_words", outw(), '0);
      repeat (3) begin
         @(posedge clk); #1;
         check("abort_quiet", bus.out_valid, 0);
      end
      do_job(0, 3, w, 0, res);
      for (int j = 0; j < 40; j++)
         do_job($urandom_range(0, 1), $urandom_range(0, 31), rnd(),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, res);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
